// File: rtl/lm96570_spi_pkg.sv
// Shared register map, control/status bit positions and shifter FSM states for the LM96570 config port.
// Optional readback logic elsewhere is selected by LM96570_READBACK_EN.
package lm96570_spi_pkg;

  localparam int unsigned CTRL_ADDR   = 0;
  localparam int unsigned STATUS_ADDR = 1;
  localparam int unsigned CLKDIV_ADDR = 2;
  localparam int unsigned TX_BASE     = 4;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } spi_state_t;

  // RX words follow directly after the TX words.
  function automatic int unsigned rx_base(input int unsigned num_words);
    return TX_BASE + num_words;
  endfunction

endpackage

// File: rtl/lm96570_spi_shifter.sv
// Frame serialiser: divider, bit counter, shift register and phase FSM driving SCLK/SDI/LE.
// With LM96570_READBACK_EN defined, SDO is synchronised and captured into rx_frame.
module lm96570_spi_shifter
  import lm96570_spi_pkg::*;
#(
  parameter int unsigned FRAME_BITS = 64,
  parameter int unsigned CLKDIV_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CLKDIV_W-1:0]   clkdiv,
  input  logic [FRAME_BITS-1:0] tx_frame,
`ifdef LM96570_READBACK_EN
  input  logic                  sdo,
  output logic [FRAME_BITS-1:0] rx_frame,
`endif
  output logic                  sclk,
  output logic                  sdi,
  output logic                  le,
  output logic                  busy,
  output logic                  done_pulse
);

  localparam int unsigned CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  spi_state_t              state, state_next;
  logic [CLKDIV_W-1:0]     div_q, div_next;
  logic [CLKDIV_W-1:0]     phase_cnt, phase_next;
  logic [CNT_W-1:0]        bit_cnt, bit_next;
  logic [FRAME_BITS-1:0]   sr, sr_next;
  logic                    phase_end;
  logic                    sclk_next, sdi_next, le_next, busy_next, done_next;

  assign phase_end = (phase_cnt == div_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div_q      <= '0;
      phase_cnt  <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      sclk       <= 1'b0;
      sdi        <= 1'b0;
      le         <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      div_q      <= div_next;
      phase_cnt  <= phase_next;
      bit_cnt    <= bit_next;
      sr         <= sr_next;
      sclk       <= sclk_next;
      sdi        <= sdi_next;
      le         <= le_next;
      busy       <= busy_next;
      done_pulse <= done_next;
    end
  end

  // Outputs are registered from the next state so they line up exactly with the state they describe.
  always_comb begin
    state_next = state;
    div_next   = div_q;
    phase_next = phase_cnt;
    bit_next   = bit_cnt;
    sr_next    = sr;
    unique case (state)
      IDLE: begin
        if (start) begin
          div_next   = clkdiv;
          sr_next    = tx_frame;
          bit_next   = '0;
          phase_next = '0;
          state_next = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (phase_end) begin
          phase_next = '0;
          state_next = SHIFT_HI;
        end else begin
          phase_next = phase_cnt + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (phase_end) begin
          phase_next = '0;
          if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
            state_next = LATCH;
          end else begin
            sr_next    = {sr[FRAME_BITS-2:0], 1'b0};
            bit_next   = bit_cnt + 1'b1;
            state_next = SHIFT_LO;
          end
        end else begin
          phase_next = phase_cnt + 1'b1;
        end
      end
      LATCH: begin
        if (phase_end) begin
          phase_next = '0;
          state_next = DONE;
        end else begin
          phase_next = phase_cnt + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    sclk_next = (state_next == SHIFT_HI);
    le_next   = (state_next == LATCH);
    busy_next = (state_next == SHIFT_LO) || (state_next == SHIFT_HI) || (state_next == LATCH);
    done_next = (state_next == DONE);
    sdi_next  = ((state_next == SHIFT_LO) || (state_next == SHIFT_HI)) ? sr_next[FRAME_BITS-1] : 1'b0;
  end

`ifdef LM96570_READBACK_EN
  logic                  sdo_meta, sdo_sync;
  logic [FRAME_BITS-1:0] rx_sr;

  // Capture at the end of each high phase so SDO has had the whole bit period to settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdo_meta <= 1'b0;
      sdo_sync <= 1'b0;
      rx_sr    <= '0;
    end else begin
      sdo_meta <= sdo;
      sdo_sync <= sdo_meta;
      if ((state == SHIFT_HI) && phase_end) begin
        rx_sr <= {rx_sr[FRAME_BITS-2:0], sdo_sync};
      end
    end
  end

  assign rx_frame = rx_sr;
`endif

endmodule

// File: rtl/lm96570_spi_ctrl_avmm.sv
// Avalon-MM register front end for the LM96570 serial config port: register file, read mux, done IRQ.
// Define LM96570_READBACK_EN to capture SDO into the RX words; otherwise RX addresses read 0.
module lm96570_spi_ctrl_avmm
  import lm96570_spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WORDS = 2,
  parameter int unsigned CLKDIV_W  = 8,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq,
  output logic              spi_sclk,
  output logic              spi_sdi,
  output logic              spi_le,
  input  logic              spi_sdo
);

  localparam int unsigned FRAME_BITS = DATA_W * NUM_WORDS;
  localparam int unsigned RX_BASE    = rx_base(NUM_WORDS);

  logic                  wr;
  logic                  sel_ctrl, sel_status, sel_clkdiv;
  logic                  start;
  logic                  irq_en;
  logic                  done;
  logic [CLKDIV_W-1:0]   clkdiv;
  logic [DATA_W-1:0]     tx [NUM_WORDS];
  logic [FRAME_BITS-1:0] tx_frame;
  logic                  busy;
  logic                  done_pulse;

  assign wr         = chipselect & ~write_n;
  assign sel_ctrl   = (address == ADDR_W'(CTRL_ADDR));
  assign sel_status = (address == ADDR_W'(STATUS_ADDR));
  assign sel_clkdiv = (address == ADDR_W'(CLKDIV_ADDR));
  assign start      = wr & sel_ctrl & writedata[CTRL_START_BIT];
  assign irq        = done & irq_en;

  // TX word 0 occupies the top of the frame so it is shifted out first.
  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_frame
    assign tx_frame[(NUM_WORDS-g)*DATA_W-1 -: DATA_W] = tx[g];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      done   <= 1'b0;
      clkdiv <= '0;
      for (int i = 0; i < NUM_WORDS; i++) tx[i] <= '0;
    end else begin
      if (wr && sel_ctrl)   irq_en <= writedata[CTRL_IRQ_EN_BIT];
      if (wr && sel_clkdiv) clkdiv <= writedata[CLKDIV_W-1:0];
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (wr && (address == ADDR_W'(TX_BASE + i))) tx[i] <= writedata;
      end
      // A completing frame beats a simultaneous clear so no completion is lost.
      if (done_pulse) begin
        done <= 1'b1;
      end else if (wr && sel_status && writedata[STATUS_DONE_BIT]) begin
        done <= 1'b0;
      end
    end
  end

`ifdef LM96570_READBACK_EN
  logic [FRAME_BITS-1:0] rx_frame;
  logic [DATA_W-1:0]     rx [NUM_WORDS];

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_rx
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rx[g] <= '0;
      end else if (done_pulse) begin
        rx[g] <= rx_frame[(NUM_WORDS-g)*DATA_W-1 -: DATA_W];
      end
    end
  end
`else
  logic unused_sdo;
  assign unused_sdo = spi_sdo;
`endif

  always_comb begin
    readdata = '0;
    if (sel_ctrl) begin
      readdata[CTRL_IRQ_EN_BIT] = irq_en;
    end
    if (sel_status) begin
      readdata[STATUS_BUSY_BIT] = busy;
      readdata[STATUS_DONE_BIT] = done;
    end
    if (sel_clkdiv) begin
      readdata = DATA_W'(clkdiv);
    end
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (address == ADDR_W'(TX_BASE + i)) readdata = tx[i];
`ifdef LM96570_READBACK_EN
      if (address == ADDR_W'(RX_BASE + i)) readdata = rx[i];
`endif
    end
  end

  lm96570_spi_shifter #(
    .FRAME_BITS (FRAME_BITS),
    .CLKDIV_W   (CLKDIV_W)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .clkdiv     (clkdiv),
    .tx_frame   (tx_frame),
`ifdef LM96570_READBACK_EN
    .sdo        (spi_sdo),
    .rx_frame   (rx_frame),
`endif
    .sclk       (spi_sclk),
    .sdi        (spi_sdi),
    .le         (spi_le),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

endmodule

// File: tb/tb_lm96570_spi_ctrl_avmm.sv
// Self-checking bench for lm96570_spi_ctrl_avmm: random frames checked against a cycle-level waveform model.
// RX expectations depend on LM96570_READBACK_EN.
`timescale 1ns/1ps
module tb_lm96570_spi_ctrl_avmm;

  localparam int unsigned DW = 32;
  localparam int unsigned NW = 2;
  localparam int unsigned FB = DW * NW;
  localparam int unsigned AW = 4;

  localparam logic [AW-1:0] A_CTRL   = 4'd0;
  localparam logic [AW-1:0] A_STATUS = 4'd1;
  localparam logic [AW-1:0] A_CLKDIV = 4'd2;
  localparam logic [AW-1:0] A_TX0    = 4'd4;
  localparam logic [AW-1:0] A_RX0    = 4'd6;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic          irq;
  logic          spi_sclk;
  logic          spi_sdi;
  logic          spi_le;
  logic          spi_sdo;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_tx [NW];
  logic [7:0]    m_clkdiv;
  logic          m_irq_en;
  logic          m_done;

  logic sclk_bits [$];

  always #5 clk = ~clk;

  // Every SCLK rising edge is a bit the device would clock in.
  always @(posedge spi_sclk) sclk_bits.push_back(spi_sdi);

  // One-bit device model: presents on SDO the bit it just sampled.
  always @(posedge spi_sclk or posedge reset) begin
    if (reset) spi_sdo <= 1'b0;
    else       spi_sdo <= spi_sdi;
  end

  lm96570_spi_ctrl_avmm #(
    .DATA_W    (DW),
    .NUM_WORDS (NW),
    .CLKDIV_W  (8),
    .ADDR_W    (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .spi_sclk   (spi_sclk),
    .spi_sdi    (spi_sdi),
    .spi_le     (spi_le),
    .spi_sdo    (spi_sdo)
  );

  function automatic void model_apply(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (a == A_CTRL) m_irq_en = d[1];
    else if (a == A_STATUS) begin
      if (d[1]) m_done = 1'b0;
    end
    else if (a == A_CLKDIV) m_clkdiv = d[7:0];
    else if ((a >= A_TX0) && (a < A_RX0)) m_tx[int'(a) - 4] = d;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NW; i++) m_tx[i] = '0;
    m_clkdiv = '0;
    m_irq_en = 1'b0;
    m_done   = 1'b0;
  endfunction

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_write(a, d);
    model_apply(a, d);
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    @(negedge clk);
    address = a;
    #1;
    d = readdata;
  endtask

  // Starts a frame and checks its timing, waveform and bit stream; optionally injects one write mid-frame.
  task automatic run_frame(input string tag, input int inj_cyc, input logic [AW-1:0] inj_addr,
                           input logic [DW-1:0] inj_data);
    logic [FB-1:0] frame;
    logic          s_sclk [$];
    logic          s_sdi [$];
    logic          s_le [$];
    logic [DW-1:0] rd;
    int d, e, cyc, wave_err, bit_err, ph, n;
    bit seen, inj_now;
    logic x_sclk, x_le;

    cfg_write(A_STATUS, 32'h2);
    for (int i = 0; i < NW; i++) frame[FB-1-i*DW -: DW] = m_tx[i];
    d = int'(m_clkdiv);
    e = (2*FB + 1) * (d + 1) + 1;
    sclk_bits.delete();

    @(negedge clk);
    address = A_CTRL; writedata = {{(DW-2){1'b0}}, m_irq_en, 1'b1};
    chipselect = 1'b1; write_n = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc <= e + 20) begin
      @(negedge clk);
      inj_now = (cyc == inj_cyc);
      if (inj_now) begin
        address = inj_addr; writedata = inj_data; chipselect = 1'b1; write_n = 1'b0;
      end else begin
        address = A_STATUS; chipselect = 1'b0; write_n = 1'b1;
      end
      #1;
      s_sclk.push_back(spi_sclk); s_sdi.push_back(spi_sdi); s_le.push_back(spi_le);
      if (inj_now) begin
        model_apply(inj_addr, inj_data);
        cyc++;
      end else begin
        if (cyc == 0) begin
          checks++;
          if (readdata[0] !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start: got %b expected 1", tag, readdata[0]);
          end
        end
        if (readdata[1] === 1'b1) seen = 1'b1;
        else cyc++;
      end
    end
    chipselect = 1'b0; write_n = 1'b1;

    checks++;
    if (!seen || cyc != e) begin
      errors++; $display("FAIL %s frame_cycles: got %0d (done seen %b) expected %0d", tag, cyc, seen, e);
    end

    wave_err = 0;
    n = (s_sclk.size() < e) ? s_sclk.size() : e;
    for (int idx = 0; idx < n; idx++) begin
      ph = idx / (d + 1);
      x_sclk = (ph < 2*FB) ? ph[0] : 1'b0;
      x_le   = (ph == 2*FB);
      if (s_sclk[idx] !== x_sclk || s_le[idx] !== x_le) wave_err++;
      else if (ph < 2*FB && s_sdi[idx] !== frame[FB-1-ph/2]) wave_err++;
    end
    checks++;
    if (wave_err != 0) begin
      errors++; $display("FAIL %s waveform: got %0d bad cycles expected 0", tag, wave_err);
    end

    bit_err = 0;
    if (sclk_bits.size() != FB) bit_err = 1000 + sclk_bits.size();
    else for (int i = 0; i < FB; i++) if (sclk_bits[i] !== frame[FB-1-i]) bit_err++;
    checks++;
    if (bit_err != 0) begin
      errors++; $display("FAIL %s sdi_bits: got %0d errors (edges %0d) expected 0", tag, bit_err, sclk_bits.size());
    end

    m_done = 1'b1;
    bus_read(A_STATUS, rd);
    checks++;
    if (rd[1:0] !== {m_done, 1'b0}) begin
      errors++; $display("FAIL %s status_after: got %b expected %b", tag, rd[1:0], {m_done, 1'b0});
    end
    checks++;
    if (irq !== (m_done & m_irq_en)) begin
      errors++; $display("FAIL %s irq_after: got %b expected %b", tag, irq, m_done & m_irq_en);
    end
  endtask

  task automatic check_all_regs_zero(input string tag);
    logic [DW-1:0] rd;
    for (int a = 0; a < 16; a++) begin
      bus_read(AW'(a), rd);
      checks++;
      if (rd !== '0) begin
        errors++; $display("FAIL %s reg%0d: got %h expected 0", tag, a, rd);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({spi_sclk, spi_sdi, spi_le, irq} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000", {spi_sclk, spi_sdi, spi_le, irq});
    end
    reset = 1'b0;
    check_all_regs_zero("reset");
  endtask

  task automatic test_basic_frame();
    cfg_write(A_CLKDIV, 32'd0);
    cfg_write(A_TX0, 32'h8000_0001);
    cfg_write(A_TX0 + 1, 32'hA5A5_A5A5);
    run_frame("basic", -1, '0, '0);
  endtask

  task automatic test_divider();
    cfg_write(A_CLKDIV, 32'd4);
    cfg_write(A_TX0, $urandom());
    cfg_write(A_TX0 + 1, $urandom());
    run_frame("div4", -1, '0, '0);
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 3; k++) begin
      cfg_write(A_CTRL, {30'b0, 1'($urandom_range(0, 1)), 1'b0});
      cfg_write(A_CLKDIV, 32'($urandom_range(0, 3)));
      for (int i = 0; i < NW; i++) cfg_write(A_TX0 + AW'(i), $urandom());
      run_frame($sformatf("rand%0d", k), -1, '0, '0);
    end
  endtask

  task automatic test_collisions();
    cfg_write(A_CTRL, 32'h0);
    cfg_write(A_CLKDIV, 32'd1);
    for (int i = 0; i < NW; i++) cfg_write(A_TX0 + AW'(i), $urandom());
    run_frame("start_busy", 10, A_CTRL, {{(DW-2){1'b0}}, m_irq_en, 1'b1});
    run_frame("tx_busy", 20, A_TX0, $urandom());
    run_frame("tx_next_div_busy", 15, A_CLKDIV, 32'd2);
    run_frame("w1c_in_done", (2*FB + 1) * (int'(m_clkdiv) + 1), A_STATUS, 32'h2);
  endtask

  task automatic test_irq();
    logic [DW-1:0] rd;
    cfg_write(A_CTRL, 32'h2);
    cfg_write(A_CLKDIV, 32'd0);
    run_frame("irq_on", -1, '0, '0);
    cfg_write(A_STATUS, 32'h2);
    bus_read(A_STATUS, rd);
    checks++;
    if (irq !== 1'b0 || rd[1] !== m_done) begin
      errors++; $display("FAIL irq_clear: got irq %b done %b expected 0 0", irq, rd[1]);
    end
    cfg_write(A_CTRL, 32'h0);
    run_frame("irq_off", -1, '0, '0);
  endtask

  task automatic test_readback();
    logic [DW-1:0] rd, exp;
    cfg_write(A_CLKDIV, 32'd3);
    for (int i = 0; i < NW; i++) cfg_write(A_TX0 + AW'(i), $urandom());
    run_frame("readback", -1, '0, '0);
    for (int i = 0; i < NW; i++) begin
      bus_read(A_RX0 + AW'(i), rd);
`ifdef LM96570_READBACK_EN
      exp = m_tx[i];
`else
      exp = '0;
`endif
      checks++;
      if (rd !== exp) begin
        errors++; $display("FAIL rx_word%0d: got %h expected %h", i, rd, exp);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] rd;
    int n;
    bit le_seen, irq_seen;
    cfg_write(A_CLKDIV, 32'd3);
    cfg_write(A_TX0, 32'hFFFF_FFFF);
    cfg_write(A_TX0 + 1, 32'hFFFF_FFFF);
    cfg_write(A_STATUS, 32'h2);
    bus_write(A_CTRL, 32'h3);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(spi_sclk === 1'b1 && n >= 20) && n < 300);
    checks++;
    if (n >= 300) begin
      errors++; $display("FAIL midreset_wait_sclk: got timeout expected sclk high");
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({spi_sclk, spi_sdi, spi_le} !== 3'b0) begin
      errors++; $display("FAIL midreset_outputs: got %b expected 000", {spi_sclk, spi_sdi, spi_le});
    end
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    check_all_regs_zero("midreset");
    le_seen = 1'b0; irq_seen = 1'b0;
    address = A_STATUS;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (spi_le !== 1'b0) le_seen = 1'b1;
      if (irq !== 1'b0 || readdata !== '0) irq_seen = 1'b1;
    end
    checks++;
    if (le_seen || irq_seen) begin
      errors++; $display("FAIL midreset_quiet: got le %b status/irq %b expected 0 0", le_seen, irq_seen);
    end
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_frame();
    test_divider();
    test_random_frames();
    test_collisions();
    test_irq();
    test_readback();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
